bubble_sort_ctrl: RTL

- Sequencer that loads a batch of DEPTH unsigned words, sorts them ascending by scheduling one compare-exchange step per clock over an internal buffer, then streams the sorted batch out.
- Bubble-sort passes with early termination: the sort stops after the first pass that performs no swap.
- Sits between a producer and a consumer, both using valid/ready handshakes.

---
 rtl/bubble_sort_ctrl_if.sv | 23 ++
 rtl/bubble_sort_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/bubble_sort_ctrl_if.sv
// Producer/consumer valid-ready stream bundle for bubble_sort_ctrl.
// slave is the sorter's view; master is the producer/consumer side.
interface bubble_sort_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/bubble_sort_ctrl.sv
// Batch sorter: loads DEPTH words, bubble-sorts them one compare-exchange per clock with
// early termination, then streams them out ascending.
module bubble_sort_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bubble_sort_ctrl_if.slave        bus,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   pass_cnt_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StLoad, StSort, StDrain} state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q, idx_q, limit_q;
  logic                swapped_q;
  logic [CntW-1:0]     pass_cnt_q;
  logic                in_ready_q, out_valid_q, out_last_q, busy_q;
  logic [WIDTH-1:0]    out_data_q;

  logic [WIDTH-1:0]    cmp_a, cmp_b;
  logic                do_swap, any_swap, last_pair;

  always_comb begin
    cmp_a     = mem_q[idx_q];
    cmp_b     = mem_q[idx_q + 1'b1];
    // Strict compare keeps equal words in place, so the sort is stable.
    do_swap   = cmp_a > cmp_b;
    any_swap  = swapped_q | do_swap;
    last_pair = (idx_q == limit_q - 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StLoad;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      idx_q       <= '0;
      limit_q     <= '0;
      swapped_q   <= 1'b0;
      pass_cnt_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (bus.in_valid && in_ready_q) begin
            mem_q[wr_ptr_q] <= bus.in_data;
            if (wr_ptr_q == PtrW'(DEPTH - 1)) begin
              wr_ptr_q   <= '0;
              state_q    <= StSort;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              idx_q      <= '0;
              limit_q    <= PtrW'(DEPTH - 1);
              swapped_q  <= 1'b0;
              pass_cnt_q <= CntW'(1);
            end else begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
            end
          end
        end

        StSort: begin
          if (do_swap) begin
            mem_q[idx_q]        <= cmp_b;
            mem_q[idx_q + 1'b1] <= cmp_a;
          end
          if (!last_pair) begin
            idx_q     <= idx_q + 1'b1;
            swapped_q <= any_swap;
          end else if (any_swap && limit_q > PtrW'(1)) begin
            limit_q    <= limit_q - 1'b1;
            idx_q      <= '0;
            swapped_q  <= 1'b0;
            pass_cnt_q <= pass_cnt_q + 1'b1;
          end else begin
            state_q     <= StDrain;
            busy_q      <= 1'b0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            // Word 0 may be swapped on this very cycle when the last pass is pair 0/1.
            out_data_q  <= (do_swap && idx_q == '0) ? cmp_b : mem_q[0];
          end
        end

        StDrain: begin
          if (bus.out_ready) begin
            if (rd_ptr_q == PtrW'(DEPTH - 1)) begin
              rd_ptr_q    <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= StLoad;
            end else begin
              rd_ptr_q   <= rd_ptr_q + 1'b1;
              out_data_q <= mem_q[rd_ptr_q + 1'b1];
              out_last_q <= (rd_ptr_q + 1'b1 == PtrW'(DEPTH - 1));
            end
          end
        end

        default: state_q <= StLoad;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy_o        = busy_q;
  assign pass_cnt_o    = pass_cnt_q;
endmodule
